// File: rtl/vme_rd_responder.sv
// Memory-side responder for the VME read channel: takes one read command at a
// time and streams len+1 beats from a synchronous-read SRAM port, echoing the tag.
module vme_rd_responder #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 8,
    parameter int TAG_W  = 21,
    parameter int MEM_AW = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              io_vme_rd_cmd_ready,
    input  logic              io_vme_rd_cmd_valid,
    input  logic [ADDR_W-1:0] io_vme_rd_cmd_bits_addr,
    input  logic [LEN_W-1:0]  io_vme_rd_cmd_bits_len,
    input  logic [TAG_W-1:0]  io_vme_rd_cmd_bits_tag,
    output logic              io_vme_rd_data_valid,
    output logic [DATA_W-1:0] io_vme_rd_data_bits_data,
    output logic [TAG_W-1:0]  io_vme_rd_data_bits_tag,
    output logic              io_vme_rd_data_bits_last,
    output logic              io_mem_rd_en,
    output logic [MEM_AW-1:0] io_mem_rd_addr,
    input  logic [DATA_W-1:0] io_mem_rd_data,
    output logic              io_busy,
    output logic              io_err_unaligned
);

    localparam int BYTE_SH = $clog2(DATA_W / 8);

    typedef enum logic {IDLE, BURST} state_e;

    state_e            state_q, state_d;
    logic [MEM_AW-1:0] waddr_q, waddr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              err_q, err_d;
    logic              vld_q, last_q;
    logic              rd_en, issue_last, cmd_ready;
    logic              cmd_unaligned;
    logic [1:0]        rst_sync_q;
    logic              rst_n;

    // Reset asserts immediately but releases only after two clean clock edges.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    generate
        if (BYTE_SH > 0) begin : g_align
            assign cmd_unaligned = |io_vme_rd_cmd_bits_addr[BYTE_SH-1:0];
        end else begin : g_no_align
            assign cmd_unaligned = 1'b0;
        end
        if (ADDR_W > BYTE_SH + MEM_AW) begin : g_hi_addr
            // Address bits above the SRAM window fold away (modulo addressing).
            logic unused_hi_addr;
            assign unused_hi_addr = ^io_vme_rd_cmd_bits_addr[ADDR_W-1:BYTE_SH+MEM_AW];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        waddr_d    = waddr_q;
        rem_d      = rem_q;
        tag_d      = tag_q;
        err_d      = err_q;
        cmd_ready  = 1'b0;
        rd_en      = 1'b0;
        issue_last = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = rst_n;
                if (io_vme_rd_cmd_valid && rst_n) begin
                    waddr_d = io_vme_rd_cmd_bits_addr[BYTE_SH +: MEM_AW];
                    rem_d   = io_vme_rd_cmd_bits_len;
                    tag_d   = io_vme_rd_cmd_bits_tag;
                    err_d   = err_q | cmd_unaligned;
                    state_d = BURST;
                end
            end
            BURST: begin
                rd_en   = 1'b1;
                waddr_d = waddr_q + MEM_AW'(1);
                if (rem_q == '0) begin
                    issue_last = 1'b1;
                    state_d    = IDLE;
                end else begin
                    rem_d = rem_q - LEN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            waddr_q <= '0;
            rem_q   <= '0;
            tag_q   <= '0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            rem_q   <= rem_d;
            tag_q   <= tag_d;
            err_q   <= err_d;
            vld_q   <= rd_en;
            last_q  <= issue_last;
        end
    end

    // tag_q only changes on accept, which cannot happen while older beats are still due.
    assign io_vme_rd_cmd_ready      = cmd_ready;
    assign io_mem_rd_en             = rd_en;
    assign io_mem_rd_addr           = waddr_q;
    assign io_vme_rd_data_valid     = vld_q;
    assign io_vme_rd_data_bits_data = vld_q ? io_mem_rd_data : '0;
    assign io_vme_rd_data_bits_tag  = vld_q ? tag_q : '0;
    assign io_vme_rd_data_bits_last = last_q;
    assign io_busy                  = (state_q == BURST) | vld_q;
    assign io_err_unaligned         = err_q;

endmodule

// File: tb/tb_vme_rd_responder.sv
// Scoreboard bench for vme_rd_responder: expected beats and SRAM addresses are
// queued when a command is accepted and compared as the DUT produces them.
module tb_vme_rd_responder;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_ready, cmd_valid;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [20:0] cmd_tag;
    logic        d_valid, d_last, rd_en, busy, err;
    logic [63:0] d_data, mem_rd_data;
    logic [20:0] d_tag;
    logic [15:0] rd_addr;

    logic [63:0] mem [0:65535];

    typedef struct {
        logic [63:0] data;
        logic [20:0] tag;
        logic        last;
        int          cyc;
    } beat_t;

    beat_t       sb[$];
    logic [15:0] aq[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    vme_rd_responder dut (
        .clock                    (clock),
        .reset_n                  (reset_n),
        .io_vme_rd_cmd_ready      (cmd_ready),
        .io_vme_rd_cmd_valid      (cmd_valid),
        .io_vme_rd_cmd_bits_addr  (cmd_addr),
        .io_vme_rd_cmd_bits_len   (cmd_len),
        .io_vme_rd_cmd_bits_tag   (cmd_tag),
        .io_vme_rd_data_valid     (d_valid),
        .io_vme_rd_data_bits_data (d_data),
        .io_vme_rd_data_bits_tag  (d_tag),
        .io_vme_rd_data_bits_last (d_last),
        .io_mem_rd_en             (rd_en),
        .io_mem_rd_addr           (rd_addr),
        .io_mem_rd_data           (mem_rd_data),
        .io_busy                  (busy),
        .io_err_unaligned         (err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // Synchronous-read SRAM model
    always @(posedge clock) if (rd_en) mem_rd_data <= mem[rd_addr];

    task automatic chk(input string tg, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tg, got, exp, cyc);
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (rd_en) begin
                if (aq.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("rd_addr", rd_addr, aq.pop_front());
            end
            if (d_valid) begin
                if (sb.size() == 0) chk("beat_unexpected", 1, 0);
                else begin
                    beat_t b;
                    b = sb.pop_front();
                    chk("beat_data", d_data, b.data);
                    chk("beat_tag", d_tag, b.tag);
                    chk("beat_last", d_last, b.last);
                    chk("beat_cycle", cyc, b.cyc);
                end
            end else begin
                chk("idle_tag", d_tag, 0);
                chk("idle_last", d_last, 0);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the accept.
    task automatic send_cmd(input logic [31:0] a, input logic [7:0] l, input logic [20:0] t,
                            output int acc, output int lat);
        int c0;
        logic [15:0] w;
        beat_t b;
        c0 = cyc;
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_tag = t;
        acc = -1;
        for (int i = 0; i < 100 && acc < 0; i++) begin
            @(negedge clock);
            if (cmd_ready) acc = cyc;
        end
        lat = acc - c0;
        if (acc < 0) chk("accept_timeout", 0, 1);
        else begin
            w = a[18:3];
            for (int i = 0; i <= int'(l); i++) begin
                aq.push_back(w);
                b.data = mem[w]; b.tag = t; b.last = (i == int'(l)); b.cyc = acc + 2 + i;
                sb.push_back(b);
                w = w + 16'd1;
            end
        end
        @(posedge clock); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clock);
            if (sb.size() == 0 && aq.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 0, 1);
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, lat;
        for (int k = 0; k < 65536; k++) mem[k] = 64'(k);
        mem[16'h20] = 64'hA5A5;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_tag = '0;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_valid", d_valid, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        @(posedge clock); #1; reset_n = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("post_rst_ready", cmd_ready, 1);

        // Single beat
        @(posedge clock); #1;
        send_cmd(32'h100, 8'd0, 21'd7, t1, lat);
        chk("single_same_cycle", lat, 0);
        @(negedge clock);
        @(negedge clock); chk("single_busy_beat", busy, 1);
        @(negedge clock); chk("single_busy_drop", busy, 0);
        wait_idle();

        // Burst of 4 with ready low for 4 cycles
        send_cmd(32'h40, 8'd3, 21'h1F, t1, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("burst_ready", cmd_ready, (i == 4));
        end
        wait_idle();

        // Back-to-back, valid held across both commands
        send_cmd(32'h200, 8'd1, 21'd1, t1, lat);
        send_cmd(32'h300, 8'd1, 21'd2, t2, lat);
        chk("b2b_accept", t2, t1 + 3);
        wait_idle();

        // SRAM address wrap
        send_cmd(32'((65536 - 2) * 8), 8'd3, 21'h55, t1, lat);
        wait_idle();
        chk("err_before_unaligned", err, 0);

        // Unaligned: sticky error
        send_cmd(32'h103, 8'd0, 21'h3, t1, lat);
        wait_idle();
        chk("err_unaligned", err, 1);
        send_cmd(32'h80, 8'd2, 21'h4, t1, lat);
        wait_idle();
        chk("err_sticky", err, 1);

        // Reset during the second beat of an 8-beat burst
        send_cmd(32'h0, 8'd7, 21'h6, t1, lat);
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", d_valid, 0);
        chk("arst_last", d_last, 0);
        chk("arst_rd_en", rd_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_err", err, 0);
        sb.delete();
        aq.delete();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("arst_ready", cmd_ready, 1);
        @(posedge clock); #1;
        send_cmd(32'h1000, 8'd2, 21'h9, t1, lat);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
